// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector on a single clock, advanced by an
// internal clock-enable strobe, with configurable overlap/output style and a saturating hit counter.
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0011,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 MOORE   = 1'b0,
  parameter int                 DIV     = 100000000,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             w,
  output logic             tick,
  output logic             z,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [5:0]       fill
);

  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $error("seq_detect_param: PAT_LEN must be in 2..32");
  end
  if (DIV < 1) begin : g_bad_div
    $error("seq_detect_param: DIV must be at least 1");
  end

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [5:0]     FILL_MAX = 6'(PAT_LEN);
  localparam logic [5:0]     FILL_ARM = 6'(PAT_LEN - 1);

  logic [DW-1:0]      div_cnt;
  logic [PAT_LEN-2:0] hist;
  logic [PAT_LEN-1:0] cand;
  logic               hit;
  logic               z_q;

  // Gated by rst so that DIV=1 does not strobe while held in reset.
  assign tick = rst & ~clr & (div_cnt == DIV_LAST);
  assign cand = {hist, w};
  assign hit  = tick & (fill >= FILL_ARM) & (cand == PATTERN);
  assign z    = MOORE ? z_q : hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      hist    <= '0;
      fill    <= '0;
      hit_cnt <= '0;
      z_q     <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      hist    <= '0;
      fill    <= '0;
      hit_cnt <= '0;
      z_q     <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (tick) begin
        hist <= cand[PAT_LEN-2:0];
        z_q  <= hit;
        // Non-overlapping mode keeps shifting hist but invalidates it via fill.
        if (hit && !OVERLAP)
          fill <= '0;
        else if (fill < FILL_MAX)
          fill <= fill + 1'b1;
      end
      if (hit && (hit_cnt != '1))
        hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: four detector configurations share one random/directed
// serial stream and are checked every cycle against a bit-history model.
module tb_seq_detect_param;

  localparam int NI = 4;
  localparam int PL [NI] = '{4, 3, 4, 2};
  localparam int PT [NI] = '{3, 5, 3, 3};
  localparam int OV [NI] = '{1, 0, 1, 1};
  localparam int MO [NI] = '{0, 0, 1, 0};
  localparam int DV [NI] = '{1, 1, 4, 1};
  localparam int CW [NI] = '{8, 8, 8, 2};

  logic clk, rst, clr, w;
  logic       tk [NI];
  logic       zz [NI];
  logic [5:0] fl [NI];
  logic [7:0] hc0, hc1, hc2;
  logic [1:0] hc3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       t;
    logic       z;
    logic [7:0] c;
    logic [5:0] f;
  } exp_t;
  exp_t sb [$];

  // model state: edges since reset/clear, valid bit count, recent bits, hits
  int          cyc  [NI];
  int          nb   [NI];
  int unsigned rec  [NI];
  int          hits [NI];
  logic        zq   [NI];
  logic        et   [NI];
  logic        eh   [NI];

  initial clk = 1'b1;
  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1), .MOORE(1'b0), .DIV(1), .CNT_W(8))
    u_a (.clk(clk), .rst(rst), .clr(clr), .w(w), .tick(tk[0]), .z(zz[0]), .hit_cnt(hc0), .fill(fl[0]));
  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .MOORE(1'b0), .DIV(1), .CNT_W(8))
    u_b (.clk(clk), .rst(rst), .clr(clr), .w(w), .tick(tk[1]), .z(zz[1]), .hit_cnt(hc1), .fill(fl[1]));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1), .MOORE(1'b1), .DIV(4), .CNT_W(8))
    u_c (.clk(clk), .rst(rst), .clr(clr), .w(w), .tick(tk[2]), .z(zz[2]), .hit_cnt(hc2), .fill(fl[2]));
  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .MOORE(1'b0), .DIV(1), .CNT_W(2))
    u_d (.clk(clk), .rst(rst), .clr(clr), .w(w), .tick(tk[3]), .z(zz[3]), .hit_cnt(hc3), .fill(fl[3]));

  function automatic logic [7:0] hcnt(input int k);
    case (k)
      0:       return hc0;
      1:       return hc1;
      2:       return hc2;
      default: return {6'b0, hc3};
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic mreset(input int k);
    cyc[k]  = 0;
    nb[k]   = 0;
    rec[k]  = 0;
    hits[k] = 0;
    zq[k]   = 1'b0;
  endtask

  // One clk cycle: drive inputs, queue the expected outputs, advance the model at the edge.
  task automatic step(input logic r, input logic c, input logic wv);
    exp_t        e;
    int unsigned mask;
    rst = r;
    clr = c;
    w   = wv;
    for (int k = 0; k < NI; k++) begin
      if (!r) mreset(k);
      mask  = (32'd1 << PL[k]) - 1;
      et[k] = r && !c && ((cyc[k] % DV[k]) == DV[k] - 1);
      eh[k] = et[k] && (nb[k] >= PL[k] - 1) &&
              ((((rec[k] << 1) | 32'(wv)) & mask) == 32'(PT[k]));
      e.t = et[k];
      e.z = (MO[k] != 0) ? zq[k] : eh[k];
      e.c = 8'(hits[k]);
      e.f = 6'(nb[k]);
      sb.push_back(e);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (!r || c) mreset(k);
      else begin
        cyc[k]++;
        if (et[k]) begin
          rec[k] = (rec[k] << 1) | 32'(wv);
          if (eh[k] && OV[k] == 0) nb[k] = 0;
          else if (nb[k] < PL[k]) nb[k]++;
          zq[k] = eh[k];
        end
        if (eh[k] && hits[k] < (1 << CW[k]) - 1) hits[k]++;
      end
    end
    #1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input int hold);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--)
      for (int j = 0; j < hold; j++) step(1'b1, 1'b0, b[i]);
  endtask

  // monitor: every detector presents outputs each cycle; compare away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() >= NI) begin
        for (int k = 0; k < NI; k++) begin
          e = sb.pop_front();
          chk("tick", k, 32'(tk[k]), 32'(e.t));
          chk("z", k, 32'(zz[k]), 32'(e.z));
          chk("hit_cnt", k, 32'(hcnt(k)), 32'(e.c));
          chk("fill", k, 32'(fl[k]), 32'(e.f));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; w = 1'b0;
    for (int k = 0; k < NI; k++) mreset(k);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // default Mealy: 1,0,0,1,1,0,0,1,1 -> hits on bits 5 and 9
    feed(16'b1_0011_0011, 9, 1);
    chk("mealy_cnt", 0, 32'(hc0), 32'd2);

    // 1,0,1,0,1 with pattern 101, non-overlapping -> one hit
    step(1'b1, 1'b1, 1'b0);
    feed(16'b10101, 5, 1);
    chk("nonovl_cnt", 1, 32'(hc1), 32'd1);

    // six 1s with pattern 11, 2-bit counter saturates at 3
    step(1'b1, 1'b1, 1'b0);
    feed(16'b111111, 6, 1);
    chk("sat_cnt", 3, 32'(hc3), 32'd3);

    // Moore with DIV=4: one bit per tick, z held for one tick period
    step(1'b1, 1'b1, 1'b0);
    feed(16'b0011, 4, 4);
    chk("moore_z_rise", 2, 32'(zz[2]), 32'd1);
    chk("moore_cnt", 2, 32'(hc2), 32'd1);
    feed(16'b0, 1, 4);
    chk("moore_z_fall", 2, 32'(zz[2]), 32'd0);

    // reset mid-pattern discards the partial match
    step(1'b1, 1'b1, 1'b0);
    feed(16'b001, 3, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_fill", 0, 32'(fl[0]), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_fill_after", 0, 32'(fl[0]), 32'd1);
    chk("rst_cnt", 0, 32'(hc0), 32'd0);

    // clear in the cycle that would complete a match
    step(1'b1, 1'b1, 1'b0);
    feed(16'b001, 3, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_cnt", 0, 32'(hc0), 32'd0);
    chk("clr_fill", 0, 32'(fl[0]), 32'd0);

    // random traffic with occasional clear and reset
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 1'b0);

    @(negedge clk);
    chk("sb_drained", 0, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
